// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, addresses the combinational instruction ROM and registers the returned word into IF/ID.
// Latency 1 cycle (address A -> IF/ID next edge); stall freezes PC and IF/ID, a branch reloads PC and flushes IF/ID.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] PC_STEP   = 32'd1,
  parameter logic [31:0] NOP_INSTR = 32'hE2800000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus_step;

  assign imem_address = pc;
  // Modulo-2^32 increment; the wrap from all-ones to zero is intentional.
  assign pc_plus_step = pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= RESET_PC;
      if_id_pc          <= 32'd0;
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
      fetch_count       <= 32'd0;
    end else if (branch_taken) begin
      // The word fetched this cycle is wrong-path: drop it and insert a bubble.
      pc                <= branch_target;
      if_id_pc          <= 32'd0;
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
    end else if (!stall) begin
      pc                <= pc_plus_step;
      if_id_pc          <= pc_plus_step;
      if_id_instruction <= imem_instruction;
      if_id_valid       <= 1'b1;
      fetch_count       <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        vld;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] NOP = 32'hE2800000;

  instruction_fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .fetch_count       (fetch_count)
  );

  always #5 clk = ~clk;

  // Program: MOV R0,#20 at 0, MOV R1,#40 at 1, elsewhere a tag word CAFE_<addr[15:0]>.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd0) return 32'hE3A00014;
    if (a == 32'd1) return 32'hE3A01028;
    return {16'hCAFE, a[15:0]};
  endfunction

  always_comb imem_instruction = mem(imem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] tgt,
                      input logic [31:0] addr, input logic [31:0] ipc, input logic [31:0] instr,
                      input logic vld, input logic [31:0] cnt);
    exp_t e;
    @(negedge clk);
    rst           = r;
    stall         = s;
    branch_taken  = b;
    branch_target = tgt;
    e.addr = addr; e.ipc = ipc; e.instr = instr; e.vld = vld; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Monitor: each vector's expectation describes the state right after the following rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("imem_address",      imem_address,        e.addr);
        check("if_id_pc",          if_id_pc,            e.ipc);
        check("if_id_instruction", if_id_instruction,   e.instr);
        check("if_id_valid",       {31'd0, if_id_valid}, {31'd0, e.vld});
        check("fetch_count",       fetch_count,         e.cnt);
      end
    end
  end

  initial begin
    //    rst   stall br    target         addr           ipc            instr          vld   cnt
    step(1'b1, 1'b0, 1'b0, 32'd0,         32'd0,         32'd0,         NOP,           1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0,         32'd0,         32'd0,         NOP,           1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd1,         32'd1,         32'hE3A00014,  1'b1, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd2,         32'd2,         32'hE3A01028,  1'b1, 32'd2);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd3,         32'd3,         32'hCAFE0002,  1'b1, 32'd3);
    // Stall three cycles at pc=3, then release.
    step(1'b0, 1'b1, 1'b0, 32'd0,         32'd3,         32'd3,         32'hCAFE0002,  1'b1, 32'd3);
    step(1'b0, 1'b1, 1'b0, 32'd0,         32'd3,         32'd3,         32'hCAFE0002,  1'b1, 32'd3);
    step(1'b0, 1'b1, 1'b0, 32'd0,         32'd3,         32'd3,         32'hCAFE0002,  1'b1, 32'd3);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd4,         32'd4,         32'hCAFE0003,  1'b1, 32'd4);
    // Branch to 37, then back-to-back branch to 28 from pc=37.
    step(1'b0, 1'b0, 1'b1, 32'd37,        32'd37,        32'd0,         NOP,           1'b0, 32'd4);
    step(1'b0, 1'b0, 1'b1, 32'd28,        32'd28,        32'd0,         NOP,           1'b0, 32'd4);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd29,        32'd29,        32'hCAFE001C,  1'b1, 32'd5);
    // Branch with simultaneous stall: branch wins.
    step(1'b0, 1'b1, 1'b1, 32'd5,         32'd5,         32'd0,         NOP,           1'b0, 32'd5);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd6,         32'd6,         32'hCAFE0005,  1'b1, 32'd6);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd7,         32'd7,         32'hCAFE0006,  1'b1, 32'd7);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd8,         32'd8,         32'hCAFE0007,  1'b1, 32'd8);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd9,         32'd9,         32'hCAFE0008,  1'b1, 32'd9);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd10,        32'd10,        32'hCAFE0009,  1'b1, 32'd10);
    step(1'b0, 1'b1, 1'b0, 32'd0,         32'd10,        32'd10,        32'hCAFE0009,  1'b1, 32'd10);
    // Reset at pc=10 while stalled and branching: reset wins.
    step(1'b1, 1'b1, 1'b1, 32'd99,        32'd0,         32'd0,         NOP,           1'b0, 32'd0);
    // Wrap: branch to all-ones then fetch.
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         NOP,           1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd0,         32'd0,         32'hCAFEFFFF,  1'b1, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0,         32'd1,         32'd1,         32'hE3A00014,  1'b1, 32'd2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Pipeline IF stage of the ARM core; sits directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the combinational instruction ROM.
- Captures the returned instruction, together with PC+step, into the IF/ID pipeline register.
- Honours hazard stalls and branch redirects from later stages, and keeps a count of retired fetches.

Parameters:
- RESET_PC, 32'd0: PC value loaded on reset.
- PC_STEP, 32'd1: PC increment per fetch. Instruction memory is word-indexed, so the step is 1, not 4.
- NOP_INSTR, 32'hE2800000: bubble encoding inserted on reset or flush (ADD R0, R0, #0).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- stall, input, 1: hazard freeze; holds PC and the IF/ID register.
- branch_taken, input, 1: redirect request from the execute stage.
- branch_target, input, 32: word address to redirect to.
- imem_address, output, 32: address driven to instruction memory.
- imem_instruction, input, 32: instruction returned by memory, same cycle.
- if_id_pc, output, 32: registered PC+PC_STEP of the captured instruction.
- if_id_instruction, output, 32: registered instruction.
- if_id_valid, output, 1: 1 when the IF/ID register holds a real instruction; 0 for a bubble.
- fetch_count, output, 32: number of instructions captured into IF/ID since reset.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- imem_address = pc, combinational. It is always valid, including during reset (then it equals the current pc register).
- Per-edge priority: rst > branch_taken > stall > normal fetch.
- rst = 1:
  - pc <= RESET_PC, if_id_pc <= 0, if_id_instruction <= NOP_INSTR, if_id_valid <= 0, fetch_count <= 0.
  - Reset asserted mid-stall or mid-branch overrides both.
- branch_taken = 1 (no rst):
  - pc <= branch_target.
  - IF/ID flushed: if_id_instruction <= NOP_INSTR, if_id_pc <= 0, if_id_valid <= 0.
  - fetch_count unchanged; the wrong-path fetch is discarded.
  - Overrides a simultaneous stall.
- stall = 1 (no rst, no branch): pc, IF/ID fields, if_id_valid and fetch_count all hold.
- Normal fetch:
  - pc <= pc + PC_STEP.
  - if_id_pc <= pc + PC_STEP, if_id_instruction <= imem_instruction, if_id_valid <= 1.
  - fetch_count <= fetch_count + 1.
- Latency: the instruction at address A appears on if_id_instruction one cycle after imem_address = A.
- Arithmetic: pc + PC_STEP is 32-bit modulo. pc = 32'hFFFFFFFF with step 1 wraps to 0, with no error flag. fetch_count also wraps modulo 2^32.
- branch_target is taken verbatim: no alignment check, no range check.
- Consecutive branch_taken cycles: each one reloads pc, and IF/ID stays a bubble throughout.
- Back-to-back stall then release: the instruction presented on the release cycle is the one at the held pc. No fetch is lost or duplicated.

Test Plan:
- Reset then run, memory model = program MOV R0,#20 (E3A00014) at 0, MOV R1,#40 (E3A01028) at 1 -> imem_address goes 0,1,2. At cycle 1: if_id_instruction = E3A00014, if_id_pc = 1, valid = 1. At cycle 2: E3A01028, if_id_pc = 2, fetch_count = 2.
- Stall held 3 cycles at pc = 3 -> imem_address stays 3 and IF/ID holds the instruction from address 2. On release, the next capture is address 3's word and fetch_count increments exactly once.
- branch_taken with branch_target = 28 while pc = 37 -> next cycle pc = 28, if_id_instruction = E2800000, valid = 0, fetch_count unchanged. The following cycle captures address 28's word.
- branch_taken and stall asserted together, target 5 -> pc = 5 and IF/ID is flushed; the stall is ignored.
- rst asserted for 1 cycle mid-run at pc = 10 with stall = 1 -> pc = 0, all IF/ID outputs at reset values, fetch_count = 0.
- Force pc = 32'hFFFFFFFF via branch_target, then fetch once -> imem_address = 0 next cycle and if_id_pc = 0.
